// File: rtl/dac_pattern_gen.sv
// Multi-channel DAC waveform generator: a rate counter paces bursts of 24-bit
// frames (one per channel) handed to an SPI master over an in_ena/busy handshake.
//
// state   | meaning
// IDLE    | waiting for a rate tick
// LOAD    | register frame for current channel, strobe out_ena
// WAIT_HI | wait for SPI master to take the frame (busy rises)
// WAIT_LO | wait for transfer end (busy falls), then next channel or ADVANCE
// ADVANCE | step the waveform register once per burst
module dac_pattern_gen #(
    parameter int         CNT_LIMIT = 99,
    parameter int         N_CH      = 1,
    parameter int         DATA_W    = 16,
    parameter int         STEP      = 1,
    parameter logic [3:0] CMD       = 4'b0011
) (
    input  logic              sys_clk,
    input  logic              n_rst_fpga,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] const_value,
    input  logic              busy,
    output logic              out_ena,
    output logic [23:0]       out_data,
    output logic [DATA_W-1:0] cur_value,
    output logic              burst_active,
    output logic              overrun
);

    localparam int                CW      = (CNT_LIMIT > 0) ? $clog2(CNT_LIMIT + 1) : 1;
    localparam logic [CW-1:0]     CNT_TC  = CW'(CNT_LIMIT);
    localparam logic [DATA_W-1:0] MAX     = '1;
    localparam logic [DATA_W-1:0] STEP_V  = DATA_W'(STEP);
    localparam logic [DATA_W-1:0] TOP     = MAX - STEP_V;
    localparam logic [3:0]        LAST_CH = 4'(N_CH - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_HI,
        WAIT_LO,
        ADVANCE
    } state_t;

    state_t            state, next_state;
    logic [CW-1:0]     cnt;
    logic              tick;
    logic [3:0]        ch;
    logic [1:0]        mode_r;
    logic              dir_down, dir_next;
    logic [DATA_W-1:0] wave_next;
    logic [DATA_W-1:0] frame_value;
    logic [15:0]       frame_field;

    assign tick = (cnt == CNT_TC) && en;

    always_ff @(posedge sys_clk or negedge n_rst_fpga) begin
        if (!n_rst_fpga) begin
            cnt <= '0;
        end else if (!en || cnt == CNT_TC) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge n_rst_fpga) begin
        if (!n_rst_fpga) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (tick) next_state = LOAD;
            LOAD:    next_state = WAIT_HI;
            WAIT_HI: if (busy) next_state = WAIT_LO;
            WAIT_LO: if (!busy) next_state = (ch != LAST_CH) ? LOAD : ADVANCE;
            ADVANCE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Triangle clamps to the rails rather than folding the overshoot back.
    always_comb begin
        wave_next = cur_value;
        dir_next  = dir_down;
        case (mode_r)
            2'd0: wave_next = cur_value + STEP_V;
            2'd1: begin
                if (!dir_down) begin
                    if (cur_value > TOP) begin
                        wave_next = MAX;
                        dir_next  = 1'b1;
                    end else begin
                        wave_next = cur_value + STEP_V;
                    end
                end else begin
                    if (cur_value < STEP_V) begin
                        wave_next = '0;
                        dir_next  = 1'b0;
                    end else begin
                        wave_next = cur_value - STEP_V;
                    end
                end
            end
            2'd3:    wave_next = (cur_value == '0) ? MAX : '0;
            default: wave_next = cur_value;
        endcase
    end

    assign frame_value = (mode_r == 2'd2) ? const_value : cur_value;
    assign frame_field = 16'(frame_value) << (16 - DATA_W);

    always_ff @(posedge sys_clk or negedge n_rst_fpga) begin
        if (!n_rst_fpga) begin
            ch           <= '0;
            mode_r       <= '0;
            cur_value    <= '0;
            dir_down     <= 1'b0;
            out_ena      <= 1'b0;
            out_data     <= '0;
            burst_active <= 1'b0;
        end else begin
            out_ena      <= (state == LOAD);
            burst_active <= (next_state != IDLE);
            if (state == IDLE && tick) begin
                ch     <= '0;
                mode_r <= mode;
            end
            if (state == LOAD) begin
                out_data <= {CMD, frame_field, ch};
            end
            if (state == WAIT_LO && !busy && ch != LAST_CH) begin
                ch <= ch + 1'b1;
            end
            if (state == ADVANCE) begin
                cur_value <= wave_next;
                dir_down  <= dir_next;
            end
        end
    end

    // A tick that finds the FSM busy is dropped and only flagged.
    always_ff @(posedge sys_clk or negedge n_rst_fpga) begin
        if (!n_rst_fpga) begin
            overrun <= 1'b0;
        end else if (!en) begin
            overrun <= 1'b0;
        end else if (tick && state != IDLE) begin
            overrun <= 1'b1;
        end
    end

endmodule
